// File: rtl/l2_line_width_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : l2_line_width_bridge_if
// Description : Arbiter-side and L2-side signal bundle for the line width
//               bridge; slave = bridge view, master = arbiter/L2 view.
// Revision    : 1.0 - initial release
// ============================================================================
interface l2_line_width_bridge_if #(
    parameter int ADDR_W   = 32,
    parameter int L2_LINE  = 256,
    parameter int ARB_LINE = 128
);
    logic                    arb_read;
    logic                    arb_write;
    logic [ADDR_W-1:0]       arb_address;
    logic [ARB_LINE-1:0]     arb_wdata;
    logic [ARB_LINE/8-1:0]   arb_wmask;
    logic [ARB_LINE-1:0]     arb_rdata;
    logic                    arb_resp;
    logic                    l2_read;
    logic                    l2_write;
    logic [ADDR_W-1:0]       l2_address;
    logic [L2_LINE-1:0]      l2_wdata;
    logic [L2_LINE/8-1:0]    l2_byte_enable;
    logic [L2_LINE-1:0]      l2_rdata;
    logic                    l2_resp;

    modport slave (
        input  arb_read, arb_write, arb_address, arb_wdata, arb_wmask,
        input  l2_rdata, l2_resp,
        output arb_rdata, arb_resp,
        output l2_read, l2_write, l2_address, l2_wdata, l2_byte_enable
    );

    modport master (
        output arb_read, arb_write, arb_address, arb_wdata, arb_wmask,
        output l2_rdata, l2_resp,
        input  arb_rdata, arb_resp,
        input  l2_read, l2_write, l2_address, l2_wdata, l2_byte_enable
    );
endinterface
`default_nettype wire

// File: rtl/l2_line_width_bridge.sv
`default_nettype none
// ============================================================================
// Module      : l2_line_width_bridge
// Description : Registered arbiter-line to L2-line width bridge with a
//               one-entry L2 line read buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_line_width_bridge #(
    parameter int ADDR_W   = 32,
    parameter int L2_LINE  = 256,
    parameter int ARB_LINE = 128,
    parameter bit BUF_EN   = 1'b1
) (
    input wire                    clk,
    input wire                    rst_n,
    l2_line_width_bridge_if.slave bus
);
    localparam int c_R_RATIO   = L2_LINE / ARB_LINE;
    localparam int c_SEL_W     = (c_R_RATIO > 1) ? $clog2(c_R_RATIO) : 1;
    localparam int c_ARB_BYTES = ARB_LINE / 8;
    localparam int c_L2_BYTES  = L2_LINE / 8;
    localparam int c_OFF_A     = $clog2(c_ARB_BYTES);
    localparam int c_OFF_L     = $clog2(c_L2_BYTES);
    localparam int c_TAG_W     = ADDR_W - c_OFF_L;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_L2REQ = 2'd1;
    localparam logic [1:0] c_ST_RESP  = 2'd2;

    logic [1:0]             r_state;
    logic                   r_is_write;
    logic [c_SEL_W-1:0]     r_slot;
    logic [c_TAG_W-1:0]     r_tag;
    logic [ARB_LINE-1:0]    r_wdata;
    logic [c_ARB_BYTES-1:0] r_wmask;

    logic [c_SEL_W-1:0]     w_slot;
    logic [c_TAG_W-1:0]     w_tag;
    logic                   w_buf_valid;
    logic [c_TAG_W-1:0]     w_buf_tag;
    logic [L2_LINE-1:0]     w_buf_line;
    logic                   w_hit;
    logic                   w_done;
    logic [c_L2_BYTES-1:0]  w_be;
    logic [ARB_LINE-1:0]    w_buf_slot_data;
    logic [ARB_LINE-1:0]    w_l2_slot_data;
    logic                   w_unused;

    generate
        if (c_R_RATIO > 1) begin : g_slot_multi
            assign w_slot = bus.arb_address[c_OFF_A +: c_SEL_W];
        end else begin : g_slot_single
            assign w_slot = '0;
        end
    endgenerate

    assign w_tag    = bus.arb_address[ADDR_W-1:c_OFF_L];
    assign w_hit    = w_buf_valid && (w_buf_tag == w_tag);
    assign w_done   = (r_state == c_ST_L2REQ) && bus.l2_resp;
    assign w_unused = &{1'b0, bus.arb_address[c_OFF_A-1:0]};

    always_comb begin
        w_be            = '0;
        w_buf_slot_data = '0;
        w_l2_slot_data  = '0;
        for (int s = 0; s < c_R_RATIO; s++) begin
            if (w_slot == c_SEL_W'(s)) begin
                w_be[s*c_ARB_BYTES +: c_ARB_BYTES] = bus.arb_wmask;
                w_buf_slot_data = w_buf_line[s*ARB_LINE +: ARB_LINE];
            end
            if (r_slot == c_SEL_W'(s)) begin
                w_l2_slot_data = bus.l2_rdata[s*ARB_LINE +: ARB_LINE];
            end
        end
    end

    generate
        if (BUF_EN) begin : g_buf_on
            logic               r_buf_valid;
            logic [c_TAG_W-1:0] r_buf_tag;
            logic [L2_LINE-1:0] r_buf_line;
            logic [L2_LINE-1:0] w_merged;
            logic               w_merge;

            // Keep the buffer coherent with L2 when a write lands on the buffered line.
            assign w_merge = w_done && r_is_write && r_buf_valid && (r_buf_tag == r_tag);

            always_comb begin
                w_merged = r_buf_line;
                for (int s = 0; s < c_R_RATIO; s++) begin
                    if (r_slot == c_SEL_W'(s)) begin
                        for (int b = 0; b < c_ARB_BYTES; b++) begin
                            if (r_wmask[b]) begin
                                w_merged[s*ARB_LINE + b*8 +: 8] = r_wdata[b*8 +: 8];
                            end
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_buf_valid <= 1'b0;
                    r_buf_tag   <= '0;
                    r_buf_line  <= '0;
                end else if (w_done && !r_is_write) begin
                    r_buf_valid <= 1'b1;
                    r_buf_tag   <= r_tag;
                    r_buf_line  <= bus.l2_rdata;
                end else if (w_merge) begin
                    r_buf_line  <= w_merged;
                end
            end

            assign w_buf_valid = r_buf_valid;
            assign w_buf_tag   = r_buf_tag;
            assign w_buf_line  = r_buf_line;
        end else begin : g_buf_off
            assign w_buf_valid = 1'b0;
            assign w_buf_tag   = '0;
            assign w_buf_line  = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state            <= c_ST_IDLE;
            r_is_write         <= 1'b0;
            r_slot             <= '0;
            r_tag              <= '0;
            r_wdata            <= '0;
            r_wmask            <= '0;
            bus.arb_rdata      <= '0;
            bus.arb_resp       <= 1'b0;
            bus.l2_read        <= 1'b0;
            bus.l2_write       <= 1'b0;
            bus.l2_address     <= '0;
            bus.l2_wdata       <= '0;
            bus.l2_byte_enable <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.arb_write) begin
                        r_is_write         <= 1'b1;
                        r_slot             <= w_slot;
                        r_tag              <= w_tag;
                        r_wdata            <= bus.arb_wdata;
                        r_wmask            <= bus.arb_wmask;
                        bus.l2_write       <= 1'b1;
                        bus.l2_address     <= {w_tag, {c_OFF_L{1'b0}}};
                        bus.l2_wdata       <= {c_R_RATIO{bus.arb_wdata}};
                        bus.l2_byte_enable <= w_be;
                        r_state            <= c_ST_L2REQ;
                    end else if (bus.arb_read) begin
                        r_is_write <= 1'b0;
                        r_slot     <= w_slot;
                        r_tag      <= w_tag;
                        if (w_hit) begin
                            bus.arb_rdata <= w_buf_slot_data;
                            bus.arb_resp  <= 1'b1;
                            r_state       <= c_ST_RESP;
                        end else begin
                            bus.l2_read        <= 1'b1;
                            bus.l2_address     <= {w_tag, {c_OFF_L{1'b0}}};
                            bus.l2_byte_enable <= '0;
                            r_state            <= c_ST_L2REQ;
                        end
                    end
                end
                c_ST_L2REQ: begin
                    if (bus.l2_resp) begin
                        bus.l2_read  <= 1'b0;
                        bus.l2_write <= 1'b0;
                        bus.arb_resp <= 1'b1;
                        if (!r_is_write) begin
                            bus.arb_rdata <= w_l2_slot_data;
                        end
                        r_state <= c_ST_RESP;
                    end
                end
                c_ST_RESP: begin
                    bus.arb_resp <= 1'b0;
                    r_state      <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_l2_line_width_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_line_width_bridge
// Description : Self-checking bench: random arbiter traffic against an L2
//               memory model plus one-entry buffer hit prediction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_line_width_bridge;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    l2_line_width_bridge_if #(.ADDR_W(32), .L2_LINE(256), .ARB_LINE(128)) bus ();
    l2_line_width_bridge_if #(.ADDR_W(32), .L2_LINE(128), .ARB_LINE(128)) bus1 ();

    l2_line_width_bridge #(.ADDR_W(32), .L2_LINE(256), .ARB_LINE(128), .BUF_EN(1'b1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    l2_line_width_bridge #(.ADDR_W(32), .L2_LINE(128), .ARB_LINE(128), .BUF_EN(1'b1)) u_dut_r1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: L2 contents as whole lines, and which line the bridge should be holding.
    logic [255:0] mem [int unsigned];
    bit           m_buf_valid = 1'b0;
    int unsigned  m_buf_idx   = 0;

    function automatic logic [255:0] line_of(input int unsigned idx);
        if (!mem.exists(idx)) begin
            mem[idx] = {$urandom(), $urandom(), $urandom(), $urandom(),
                        $urandom(), $urandom(), $urandom(), $urandom()};
        end
        return mem[idx];
    endfunction

    function automatic logic [255:0] rand256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic txn(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [127:0] wdata, input logic [15:0] wmask, input int delay);
        int unsigned  idx;
        int           slot;
        bit           exp_hit;
        logic [255:0] line;
        logic [127:0] exp_rdata;
        logic [31:0]  exp_be;
        logic [1:0]   exp_strobe;
        idx        = addr >> 5;
        slot       = int'(addr[4]);
        exp_hit    = !wr && m_buf_valid && (m_buf_idx == idx);
        line       = line_of(idx);
        exp_rdata  = (slot == 1) ? line[255:128] : line[127:0];
        exp_be     = (slot == 1) ? {wmask, 16'h0} : {16'h0, wmask};
        exp_strobe = wr ? 2'b01 : 2'b10;

        @(negedge clk);
        bus.arb_read    = rd;
        bus.arb_write   = wr;
        bus.arb_address = addr;
        bus.arb_wdata   = wdata;
        bus.arb_wmask   = wmask;
        @(posedge clk);
        #1;
        if (exp_hit) begin
            check("hit_resp", bus.arb_resp, 1);
            check("hit_no_l2", {bus.l2_read, bus.l2_write}, 0);
            check("hit_rdata", bus.arb_rdata, exp_rdata);
        end else begin
            for (int c = 1; c <= delay; c++) begin
                if (c > 1) begin
                    @(posedge clk);
                    #1;
                end
                check("strobe_held", {bus.l2_read, bus.l2_write}, exp_strobe);
                check("no_early_resp", bus.arb_resp, 0);
                check("l2_address", bus.l2_address, {addr[31:5], 5'b0});
                if (wr) begin
                    check("l2_wdata", bus.l2_wdata, {wdata, wdata});
                    check("l2_byte_enable", bus.l2_byte_enable, exp_be);
                end
                bus.l2_rdata = rand256();
                if (c == delay) begin
                    @(negedge clk);
                    bus.l2_resp  = 1'b1;
                    bus.l2_rdata = wr ? rand256() : line;
                end
            end
            @(posedge clk);
            #1;
            bus.l2_resp  = 1'b0;
            bus.l2_rdata = rand256();
            check("miss_resp", bus.arb_resp, 1);
            check("strobe_drop", {bus.l2_read, bus.l2_write}, 0);
            if (!wr) begin
                check("miss_rdata", bus.arb_rdata, exp_rdata);
            end
        end
        bus.arb_read  = 1'b0;
        bus.arb_write = 1'b0;
        @(posedge clk);
        #1;
        check("resp_one_cycle", bus.arb_resp, 0);
        if (!wr) begin
            check("rdata_hold", bus.arb_rdata, exp_rdata);
        end

        if (wr) begin
            for (int b = 0; b < 16; b++) begin
                if (wmask[b]) begin
                    line[slot*128 + b*8 +: 8] = wdata[b*8 +: 8];
                end
            end
            mem[idx] = line;
        end else if (!exp_hit) begin
            m_buf_valid = 1'b1;
            m_buf_idx   = idx;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [127:0] x;
        logic [127:0] d;
        logic [15:0]  m;
        int           op;
        bus.arb_read     = 1'b0;
        bus.arb_write    = 1'b0;
        bus.arb_address  = '0;
        bus.arb_wdata    = '0;
        bus.arb_wmask    = '0;
        bus.l2_rdata     = '0;
        bus.l2_resp      = 1'b0;
        bus1.arb_read    = 1'b0;
        bus1.arb_write   = 1'b0;
        bus1.arb_address = '0;
        bus1.arb_wdata   = '0;
        bus1.arb_wmask   = '0;
        bus1.l2_rdata    = '0;
        bus1.l2_resp     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_arb_resp", bus.arb_resp, 0);
        check("rst_arb_rdata", bus.arb_rdata, 0);
        check("rst_strobes", {bus.l2_read, bus.l2_write}, 0);
        check("rst_l2_address", bus.l2_address, 0);
        check("rst_l2_wdata", bus.l2_wdata, 0);
        check("rst_l2_be", bus.l2_byte_enable, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed sequence around lines 0x1000 and 0x2000.
        txn(1'b1, 1'b0, 32'h1010, '0, '0, 3);
        txn(1'b1, 1'b0, 32'h1000, '0, '0, 1);
        x = {$urandom(), $urandom(), $urandom(), $urandom()};
        txn(1'b0, 1'b1, 32'h1010, x, 16'h000F, 2);
        txn(1'b1, 1'b0, 32'h1010, '0, '0, 1);
        txn(1'b0, 1'b1, 32'h2000, x, 16'hFFFF, 1);
        txn(1'b1, 1'b0, 32'h1000, '0, '0, 1);
        txn(1'b1, 1'b0, 32'h2000, '0, '0, 2);
        txn(1'b1, 1'b1, 32'h2010, x, 16'hF0F0, 2);

        // Stray L2 completion while idle.
        @(negedge clk);
        bus.l2_resp = 1'b1;
        @(posedge clk);
        #1;
        bus.l2_resp = 1'b0;
        check("spurious_no_resp", bus.arb_resp, 0);
        check("spurious_no_strobe", {bus.l2_read, bus.l2_write}, 0);
        @(posedge clk);
        #1;
        check("spurious_no_resp2", bus.arb_resp, 0);

        // Reset in the middle of an outstanding L2 read.
        @(negedge clk);
        bus.arb_read    = 1'b1;
        bus.arb_address = 32'h1000;
        @(posedge clk);
        #1;
        check("pre_rst_l2_read", bus.l2_read, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_l2_read", bus.l2_read, 0);
        check("async_rst_address", bus.l2_address, 0);
        check("async_rst_resp", bus.arb_resp, 0);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.arb_read = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("abandoned_no_resp", bus.arb_resp, 0);
        end
        m_buf_valid = 1'b0;
        txn(1'b1, 1'b0, 32'h2000, '0, '0, 1);
        txn(1'b1, 1'b0, 32'h1000, '0, '0, 2);

        // Random traffic over four lines so hits, misses and merges all occur.
        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 3));
            d  = {$urandom(), $urandom(), $urandom(), $urandom()};
            m  = 16'($urandom());
            txn(op != 2, op >= 2, (32'h80 + 32'($urandom_range(0, 3))) << 5 | 32'($urandom_range(0, 1)) << 4,
                d, m, int'($urandom_range(1, 4)));
        end

        // Equal-width instance: lane mapping collapses to identity.
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        m = 16'($urandom());
        @(negedge clk);
        bus1.arb_write   = 1'b1;
        bus1.arb_address = 32'h400;
        bus1.arb_wdata   = d;
        bus1.arb_wmask   = m;
        @(posedge clk);
        #1;
        check("r1_write_strobe", {bus1.l2_read, bus1.l2_write}, 2'b01);
        check("r1_byte_enable", bus1.l2_byte_enable, m);
        check("r1_wdata", bus1.l2_wdata, d);
        check("r1_address", bus1.l2_address, 32'h400);
        @(negedge clk);
        bus1.l2_resp = 1'b1;
        @(posedge clk);
        #1;
        bus1.l2_resp   = 1'b0;
        bus1.arb_write = 1'b0;
        check("r1_write_resp", bus1.arb_resp, 1);
        @(posedge clk);
        x = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(negedge clk);
        bus1.arb_read    = 1'b1;
        bus1.arb_address = 32'h800;
        @(posedge clk);
        #1;
        check("r1_read_strobe", {bus1.l2_read, bus1.l2_write}, 2'b10);
        @(negedge clk);
        bus1.l2_resp  = 1'b1;
        bus1.l2_rdata = x;
        @(posedge clk);
        #1;
        bus1.l2_resp  = 1'b0;
        bus1.arb_read = 1'b0;
        check("r1_read_resp", bus1.arb_resp, 1);
        check("r1_rdata", bus1.arb_rdata, x);
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
